lsu_shift_sequencer: RTL and testbench
======================================

// Module: lsu_shift_sequencer
// PURPOSE
//   Multi-cycle execution controller for decoded load/store and shift ops.
//   Sits after the load/store/shift decoder and the register-file read stage.
//   Runs shifts iteratively, STEP bits per cycle, on a shared shifter register.
//   Sequences word loads/stores over a req/ack memory handshake and produces one writeback per op.
// PARAMETERS
//   STEP         1    shift bits per SHIFT cycle; legal values 1,2,4,8,16
//   MEM_TIMEOUT  255  max MEM cycles without mem_ack_i before error; 1..255
// PORTS
//   clk_i               in   1   clock, rising edge
//   rst_ni              in   1   asynchronous active-low reset
//   valid_i             in   1   decoded op present
//   ready_o             out  1   controller can accept (state==IDLE)
//   busy_o              out  1   ~ready_o
//   is_load_i           in   1   decoder: LW
//   is_store_i          in   1   decoder: SW
//   is_shift_i          in   1   decoder: any shift
//   shift_left_i        in   1   1=left, 0=right
//   shift_arithmetic_i  in   1   1=arithmetic right
//   shift_immediate_i   in   1   1=amount from shamt_i, 0=rs2_data_i[4:0]
//   rs1_data_i          in   32  base address / shift operand
//   rs2_data_i          in   32  store data / shift amount source
//   immediate_i         in   32  sign-extended I/S offset
//   shamt_i             in   5   immediate shift amount
//   rd_i                in   5   destination register
//   mem_req_o           out  1   memory request, held until ack/timeout
//   mem_we_o            out  1   1=store
//   mem_addr_o          out  32  rs1+imm, word aligned
//   mem_wdata_o         out  32  store data
//   mem_ack_i           in   1   memory accepted/returned (1-cycle pulse)
//   mem_rdata_i         in   32  load data, valid with mem_ack_i
//   wb_valid_o          out  1   1-cycle writeback strobe
//   wb_rd_o             out  5   writeback register
//   wb_data_o           out  32  writeback data
//   done_o              out  1   1-cycle pulse, op finished (incl. error)
//   error_o             out  1   1-cycle pulse with done_o: misaligned or timeout
// BEHAVIOUR
//   States: IDLE, SHIFT, MEM, WB. All outputs registered except ready_o/busy_o.
//   Reset (async, rst_ni=0): state IDLE; all outputs other than ready_o and busy_o are 0.
//   Reset mid-op aborts it: mem_req_o falls immediately; no wb/done is produced.
//   Accept when valid_i&&ready_o. All inputs are captured on accept and ignored until IDLE.
//   Priority on accept: load > store > shift. If none is set, stay IDLE with no output.
//   Shift: amt = shift_immediate_i ? shamt_i : rs2_data_i[4:0].
//     amt==0 -> WB. Otherwise SHIFT for ceil(amt/STEP) cycles.
//     Each SHIFT cycle shifts by min(STEP, remaining); SRA fills with captured bit 31.
//   Load/store: addr = rs1+imm mod 2^32. If addr[1:0]!=0 -> WB with error, no mem_req_o.
//     Otherwise MEM: mem_req_o=1, with addr/we/wdata stable until exit.
//     Ack cycle: capture mem_rdata_i, go to WB. mem_req_o is 0 in WB.
//   Timeout: counter increments per MEM cycle without ack.
//     Counter==MEM_TIMEOUT-1 without ack -> WB with error.
//     Ack arriving on the timeout cycle wins (no error).
//   WB (1 cycle): done_o=1. wb_valid_o=1 only for a shift/load with no error and rd!=0.
//     wb_rd_o/wb_data_o hold the result. Next state is IDLE; ready_o rises the following cycle.
//   Latency (accept at cycle t), counting the WB cycle:
//     shift: WB at t+1+ceil(amt/STEP);
//     mem: WB at t+1+k, where k = MEM cycle count up to and including the ack cycle (ack in first MEM cycle -> k=1);
//     misaligned: WB at t+1.
//   mem_ack_i outside MEM is ignored. No back-to-back accept: ready_o=0 during WB.
// TESTING
//   STEP=1, SLLI rs1=0x1 shamt=31 -> 31 SHIFT cycles; WB at t+32, data 0x80000000.
//   SRA rs1=0x80000000 rs2=0x24 (amt 4) -> WB data 0xF8000000; SRL same -> 0x08000000.
//   LW rs1=0x100 imm=-4, ack 3 cycles after req -> addr 0xFC; wb rd/data = mem_rdata_i.
//   SW addr 0x102 -> error_o+done_o at t+1, mem_req_o never high. SW without ack -> error after 255 MEM cycles.
//   Assert rst_ni=0 during MEM -> mem_req_o drops asynchronously; no done_o; ready_o=1 after release.

Source files
------------

// File: rtl/lsu_shift_sequencer_if.sv
// Decoded-op, memory req/ack and writeback signals between the sequencer and its neighbours.
// slave = sequencer side, master = decoder/memory/regfile side.
interface lsu_shift_sequencer_if;
    logic        valid_i;
    logic        ready_o;
    logic        busy_o;
    logic        is_load_i;
    logic        is_store_i;
    logic        is_shift_i;
    logic        shift_left_i;
    logic        shift_arithmetic_i;
    logic        shift_immediate_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [31:0] immediate_i;
    logic [4:0]  shamt_i;
    logic [4:0]  rd_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        done_o;
    logic        error_o;

    modport slave (
        input  valid_i, is_load_i, is_store_i, is_shift_i, shift_left_i,
               shift_arithmetic_i, shift_immediate_i, rs1_data_i, rs2_data_i,
               immediate_i, shamt_i, rd_i, mem_ack_i, mem_rdata_i,
        output ready_o, busy_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
               wb_valid_o, wb_rd_o, wb_data_o, done_o, error_o
    );

    modport master (
        output valid_i, is_load_i, is_store_i, is_shift_i, shift_left_i,
               shift_arithmetic_i, shift_immediate_i, rs1_data_i, rs2_data_i,
               immediate_i, shamt_i, rd_i, mem_ack_i, mem_rdata_i,
        input  ready_o, busy_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
               wb_valid_o, wb_rd_o, wb_data_o, done_o, error_o
    );
endinterface

// File: rtl/lsu_shift_sequencer.sv
// Multi-cycle controller: iterative shifts (STEP bits/cycle) and word load/store over req/ack.
// Latency: shift 1+ceil(amt/STEP), mem 1+ack cycles, misaligned 1; one WB/done cycle per op.
// Backpressure: ready only in IDLE; memory stalls hold mem_req until ack or timeout.
module lsu_shift_sequencer #(
    parameter int unsigned STEP        = 1,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    lsu_shift_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MEM, S_WB} state_e;

    localparam logic [4:0] STEP_AMT = 5'(STEP);
    localparam logic [7:0] TO_LAST  = 8'(MEM_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] shreg_q, shreg_d;
    logic [4:0]  rem_q, rem_d;
    logic        left_q, left_d;
    logic        arith_q, arith_d;
    logic        load_q, load_d;
    logic [4:0]  rd_q, rd_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic [31:0] addr_sum;
    logic [4:0]  amt;
    logic [4:0]  step_n;
    logic [31:0] shifted;

    always_comb begin
        addr_sum = bus.rs1_data_i + bus.immediate_i;
        amt      = bus.shift_immediate_i ? bus.shamt_i : bus.rs2_data_i[4:0];
        step_n   = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
        if (left_q)       shifted = shreg_q << step_n;
        else if (arith_q) shifted = 32'($signed(shreg_q) >>> step_n);
        else              shifted = shreg_q >> step_n;
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        rem_d       = rem_q;
        left_d      = left_q;
        arith_d     = arith_q;
        load_d      = load_q;
        rd_d        = rd_q;
        tcnt_d      = tcnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.valid_i && (bus.is_load_i || bus.is_store_i)) begin
                    rd_d   = bus.rd_i;
                    load_d = bus.is_load_i;
                    if (addr_sum[1:0] != 2'b00) begin
                        state_d = S_WB;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                        wb_rd_d = bus.rd_i;
                    end else begin
                        state_d     = S_MEM;
                        mem_req_d   = 1'b1;
                        mem_we_d    = !bus.is_load_i;
                        mem_addr_d  = addr_sum;
                        mem_wdata_d = bus.rs2_data_i;
                        tcnt_d      = 8'd0;
                    end
                end else if (bus.valid_i && bus.is_shift_i) begin
                    rd_d    = bus.rd_i;
                    load_d  = 1'b0;
                    left_d  = bus.shift_left_i;
                    arith_d = bus.shift_arithmetic_i;
                    if (amt == 5'd0) begin
                        state_d    = S_WB;
                        done_d     = 1'b1;
                        wb_valid_d = (bus.rd_i != 5'd0);
                        wb_rd_d    = bus.rd_i;
                        wb_data_d  = bus.rs1_data_i;
                    end else begin
                        state_d = S_SHIFT;
                        shreg_d = bus.rs1_data_i;
                        rem_d   = amt;
                    end
                end
            end
            S_SHIFT: begin
                shreg_d = shifted;
                rem_d   = rem_q - step_n;
                if (rem_q == step_n) begin
                    state_d    = S_WB;
                    done_d     = 1'b1;
                    wb_valid_d = (rd_q != 5'd0);
                    wb_rd_d    = rd_q;
                    wb_data_d  = shifted;
                end
            end
            S_MEM: begin
                // An ack on the final timeout cycle still completes normally.
                if (bus.mem_ack_i) begin
                    state_d    = S_WB;
                    mem_req_d  = 1'b0;
                    done_d     = 1'b1;
                    wb_valid_d = load_q && (rd_q != 5'd0);
                    wb_rd_d    = rd_q;
                    wb_data_d  = load_q ? bus.mem_rdata_i : 32'd0;
                end else if (tcnt_q == TO_LAST) begin
                    state_d   = S_WB;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    error_d   = 1'b1;
                    wb_rd_d   = rd_q;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            rem_q       <= '0;
            left_q      <= 1'b0;
            arith_q     <= 1'b0;
            load_q      <= 1'b0;
            rd_q        <= '0;
            tcnt_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            rem_q       <= rem_d;
            left_q      <= left_d;
            arith_q     <= arith_d;
            load_q      <= load_d;
            rd_q        <= rd_d;
            tcnt_q      <= tcnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign bus.ready_o     = (state_q == S_IDLE);
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.wb_valid_o  = wb_valid_q;
    assign bus.wb_rd_o     = wb_rd_q;
    assign bus.wb_data_o   = wb_data_q;
    assign bus.done_o      = done_q;
    assign bus.error_o     = error_q;
endmodule

// File: tb/tb_lsu_shift_sequencer.sv
// Randomized and directed bench for lsu_shift_sequencer against a whole-op reference model.
module tb_lsu_shift_sequencer;
    localparam int STEP = 1;
    localparam int TO   = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    lsu_shift_sequencer_if bus();
    lsu_shift_sequencer #(.STEP(STEP), .MEM_TIMEOUT(TO)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observations from the most recent op.
    int          lat, reqc;
    logic        wbv, err, mwe, mstable, after_ok;
    logic [4:0]  wrd;
    logic [31:0] wdat, maddr, mwdata;

    function automatic logic [31:0] ref_shift(logic [31:0] v, int a, logic left, logic arith);
        if (left)  return v << a;
        if (arith) return 32'($signed(v) >>> a);
        return v >> a;
    endfunction

    task automatic scramble_inputs();
        bus.is_load_i          = 1'($urandom);
        bus.is_store_i         = 1'($urandom);
        bus.is_shift_i         = 1'($urandom);
        bus.shift_left_i       = 1'($urandom);
        bus.shift_arithmetic_i = 1'($urandom);
        bus.shift_immediate_i  = 1'($urandom);
        bus.rs1_data_i         = $urandom;
        bus.rs2_data_i         = $urandom;
        bus.immediate_i        = $urandom;
        bus.shamt_i            = 5'($urandom);
        bus.rd_i               = 5'($urandom);
    endtask

    // Issues one op (called #1 after a posedge with the DUT idle), answers memory
    // requests with an ack in MEM cycle ack_k (0 = never), and records the outcome.
    task automatic run_op(input logic ld, st, sh, left, arith, imm_sh,
                          input logic [31:0] rs1, rs2, imm, input logic [4:0] shamt, rd,
                          input int ack_k, input logic [31:0] rdata);
        bus.valid_i = 1'b1;  bus.is_load_i = ld;  bus.is_store_i = st;  bus.is_shift_i = sh;
        bus.shift_left_i = left;  bus.shift_arithmetic_i = arith;  bus.shift_immediate_i = imm_sh;
        bus.rs1_data_i = rs1;  bus.rs2_data_i = rs2;  bus.immediate_i = imm;
        bus.shamt_i = shamt;  bus.rd_i = rd;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        scramble_inputs();
        lat = -1; reqc = 0; mstable = 1'b1; maddr = 0; mwe = 0; mwdata = 0;
        wbv = 0; err = 0; wrd = 0; wdat = 0;
        for (int n = 0; n < 400; n++) begin
            if (bus.mem_req_o) begin
                if (reqc > 0 && (bus.mem_addr_o !== maddr || bus.mem_we_o !== mwe ||
                                 bus.mem_wdata_o !== mwdata)) mstable = 1'b0;
                reqc++;
                maddr = bus.mem_addr_o;  mwe = bus.mem_we_o;  mwdata = bus.mem_wdata_o;
                bus.mem_ack_i   = (reqc == ack_k);
                bus.mem_rdata_i = (reqc == ack_k) ? rdata : $urandom;
            end else begin
                bus.mem_ack_i = 1'b0;
            end
            if (bus.done_o === 1'b1) begin
                lat = n;  wbv = bus.wb_valid_o;  err = bus.error_o;
                wrd = bus.wb_rd_o;  wdat = bus.wb_data_o;
                break;
            end
            @(posedge clk); #1;
        end
        bus.mem_ack_i = 1'b0;
        @(posedge clk); #1;
        after_ok = (bus.done_o === 1'b0) && (bus.ready_o === 1'b1) && (bus.mem_req_o === 1'b0);
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.ready_o, bus.busy_o} !== 2'b10) begin
            failures++; $display("FAIL reset_ready got=%b want=10", {bus.ready_o, bus.busy_o});
        end
        checks++;
        if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.wb_valid_o,
             bus.wb_rd_o, bus.wb_data_o, bus.done_o, bus.error_o} !== '0) begin
            failures++; $display("FAIL reset_outputs got=nonzero want=0 (addr=%h data=%h)",
                                 bus.mem_addr_o, bus.wb_data_o);
        end
    endtask

    task automatic test_shift_directed();
        run_op(0, 0, 1, 1, 0, 1, 32'h1, 32'h0, 32'h0, 5'd31, 5'd3, 0, 0);
        checks++;
        if (lat !== 31) begin failures++; $display("FAIL slli31_latency got=%0d want=31", lat); end
        checks++;
        if ({wbv, wrd, wdat} !== {1'b1, 5'd3, 32'h8000_0000}) begin
            failures++; $display("FAIL slli31_wb got=%b/%0d/%h want=1/3/80000000", wbv, wrd, wdat);
        end
        checks++;
        if (after_ok !== 1'b1) begin failures++; $display("FAIL slli31_done_pulse got=%b want=1", after_ok); end
        run_op(0, 0, 1, 0, 1, 0, 32'h8000_0000, 32'h24, 32'h0, 5'd9, 5'd7, 0, 0);
        checks++;
        if ({lat, wdat, err} !== {32'd4, 32'hF800_0000, 1'b0}) begin
            failures++; $display("FAIL sra4 got=lat%0d/%h want=lat4/f8000000", lat, wdat);
        end
        run_op(0, 0, 1, 0, 0, 0, 32'h8000_0000, 32'h24, 32'h0, 5'd9, 5'd7, 0, 0);
        checks++;
        if ({lat, wdat} !== {32'd4, 32'h0800_0000}) begin
            failures++; $display("FAIL srl4 got=lat%0d/%h want=lat4/08000000", lat, wdat);
        end
    endtask

    task automatic test_shift_random();
        for (int i = 0; i < 24; i++) begin
            logic        left, arith, imm_sh;
            logic [31:0] rs1, rs2;
            logic [4:0]  shamt, rd;
            int          a, exp_lat;
            left = 1'($urandom); arith = 1'($urandom); imm_sh = 1'($urandom);
            rs1 = $urandom; rs2 = $urandom; shamt = 5'($urandom);
            rd = (i % 5 == 0) ? 5'd0 : 5'($urandom);
            if (i == 1) begin imm_sh = 1'b1; shamt = 5'd0; end
            a = imm_sh ? int'(shamt) : int'(rs2[4:0]);
            exp_lat = (a + STEP - 1) / STEP;
            run_op(1'b0, 1'b0, 1'b1, left, arith, imm_sh, rs1, rs2, $urandom, shamt, rd, 0, 0);
            checks++;
            if (lat !== exp_lat || wdat !== ref_shift(rs1, a, left, arith) ||
                wbv !== (rd != 0) || wrd !== rd || err !== 1'b0) begin
                failures++;
                $display("FAIL shift_rand%0d got=lat%0d/%h/v%b want=lat%0d/%h/v%b", i, lat, wdat,
                         wbv, exp_lat, ref_shift(rs1, a, left, arith), rd != 0);
            end
        end
    endtask

    task automatic test_load();
        run_op(1, 0, 0, 0, 0, 0, 32'h100, 32'h0, 32'hFFFF_FFFC, 5'd0, 5'd12, 3, 32'hCAFE_F00D);
        checks++;
        if ({maddr, mwe, mstable} !== {32'hFC, 1'b0, 1'b1}) begin
            failures++; $display("FAIL lw_req got=%h/we%b/st%b want=000000fc/we0/st1", maddr, mwe, mstable);
        end
        checks++;
        if ({lat, wbv, wrd, wdat, err} !== {32'd3, 1'b1, 5'd12, 32'hCAFE_F00D, 1'b0}) begin
            failures++; $display("FAIL lw_wb got=lat%0d/%b/%0d/%h want=lat3/1/12/cafef00d", lat, wbv, wrd, wdat);
        end
        run_op(1, 0, 0, 0, 0, 0, 32'h40, 32'h0, 32'h0, 5'd0, 5'd0, 1, 32'h1234);
        checks++;
        if ({lat, wbv, err} !== {32'd1, 1'b0, 1'b0}) begin
            failures++; $display("FAIL lw_rd0 got=lat%0d/v%b want=lat1/v0", lat, wbv);
        end
    endtask

    task automatic test_store_errors();
        run_op(0, 1, 0, 0, 0, 0, 32'h100, 32'h55, 32'h2, 5'd0, 5'd4, 1, 0);
        checks++;
        if ({lat, err, reqc, wbv} !== {32'd0, 1'b1, 32'd0, 1'b0}) begin
            failures++; $display("FAIL sw_misaligned got=lat%0d/e%b/req%0d want=lat0/e1/req0", lat, err, reqc);
        end
        run_op(0, 1, 0, 0, 0, 0, 32'h200, 32'hA5A5_0001, 32'h8, 5'd0, 5'd4, 0, 0);
        checks++;
        if ({lat, err, reqc, wbv} !== {32'd255, 1'b1, 32'd255, 1'b0}) begin
            failures++; $display("FAIL sw_timeout got=lat%0d/e%b/req%0d want=lat255/e1/req255", lat, err, reqc);
        end
        checks++;
        if ({maddr, mwe, mwdata, mstable, after_ok} !== {32'h208, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1}) begin
            failures++; $display("FAIL sw_req got=%h/we%b/%h want=00000208/we1/a5a50001", maddr, mwe, mwdata);
        end
        run_op(1, 0, 0, 0, 0, 0, 32'h300, 32'h0, 32'h0, 5'd0, 5'd9, 255, 32'h0BAD_BEEF);
        checks++;
        if ({lat, err, wbv, wdat} !== {32'd255, 1'b0, 1'b1, 32'h0BAD_BEEF}) begin
            failures++; $display("FAIL ack_on_timeout got=lat%0d/e%b/v%b/%h want=lat255/e0/v1/0badbeef",
                                 lat, err, wbv, wdat);
        end
    endtask

    task automatic test_mem_random();
        for (int i = 0; i < 12; i++) begin
            logic        ld, st;
            logic [31:0] rs1, rs2, imm, rdata, addr;
            logic [4:0]  rd;
            int          k;
            logic        bad;
            ld = 1'($urandom); st = ld ? 1'($urandom) : 1'b1;
            rs1 = $urandom; rs2 = $urandom; rdata = $urandom; rd = 5'($urandom);
            imm = 32'($signed(12'($urandom)));
            if (i % 3 != 0) imm[1:0] = 2'(0 - rs1[1:0]);
            k = int'($urandom_range(1, 6));
            addr = rs1 + imm;
            bad = (addr[1:0] != 2'b00);
            run_op(ld, st, 1'($urandom), 1'b0, 1'b0, 1'b0, rs1, rs2, imm, 5'd0, rd, k, rdata);
            checks++;
            if (bad ? ({lat, err, reqc, wbv} !== {32'd0, 1'b1, 32'd0, 1'b0})
                    : (lat !== k || err !== 1'b0 || maddr !== addr || mwe !== !ld ||
                       (!ld && mwdata !== rs2) || wbv !== (ld && rd != 0) ||
                       (ld && wdat !== rdata) || mstable !== 1'b1)) begin
                failures++;
                $display("FAIL mem_rand%0d got=lat%0d/e%b/a%h/we%b/d%h want=lat%0d/e%b/a%h/we%b/d%h",
                         i, lat, err, maddr, mwe, wdat, bad ? 0 : k, bad, addr, !ld, rdata);
            end
        end
    endtask

    task automatic test_idle_ignores();
        logic bad_seen;
        bad_seen = 1'b0;
        bus.valid_i = 1'b1; bus.is_load_i = 0; bus.is_store_i = 0; bus.is_shift_i = 0;
        @(posedge clk); #1;
        bus.valid_i = 1'b0; bus.mem_ack_i = 1'b1; bus.mem_rdata_i = $urandom;
        @(posedge clk); #1;
        bus.mem_ack_i = 1'b0;
        for (int n = 0; n < 3; n++) begin
            if (bus.ready_o !== 1'b1 || bus.done_o !== 1'b0 || bus.wb_valid_o !== 1'b0 ||
                bus.mem_req_o !== 1'b0) bad_seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (bad_seen !== 1'b0) begin failures++; $display("FAIL idle_noop got=activity want=none"); end
    endtask

    task automatic test_reset_mid_mem();
        logic req_before, done_seen;
        done_seen = 1'b0;
        bus.valid_i = 1'b1; bus.is_load_i = 1; bus.is_store_i = 0; bus.is_shift_i = 0;
        bus.rs1_data_i = 32'h400; bus.immediate_i = 32'h4; bus.rd_i = 5'd5;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        req_before = bus.mem_req_o;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_before, bus.mem_req_o} !== 2'b10) begin
            failures++; $display("FAIL reset_mem_req got=%b want=10", {req_before, bus.mem_req_o});
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done_o !== 1'b0 || bus.wb_valid_o !== 1'b0) done_seen = 1'b1;
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        if (bus.done_o !== 1'b0) done_seen = 1'b1;
        checks++;
        if ({done_seen, bus.ready_o, bus.mem_req_o} !== 3'b010) begin
            failures++; $display("FAIL reset_abort got=%b want=010", {done_seen, bus.ready_o, bus.mem_req_o});
        end
    endtask

    initial begin
        bus.valid_i = 1'b0; bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
        scramble_inputs();
        #12;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        test_shift_directed();
        test_shift_random();
        test_load();
        test_store_errors();
        test_mem_random();
        test_idle_ignores();
        test_reset_mid_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
